// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Arbitrates N_REQ NTT-core requesters onto a single downstream
//               memory port. Three-state issue FSM (IDLE/ISSUE/GRANT) with a
//               one-grant mask window, an owner FIFO that routes in-order read
//               returns back to the requesting core, and a sticky error flag
//               for unsolicited returns.
//               Optional macro MEM_ARB_FIXED_PRIO_EN selects fixed priority
//               (lowest index wins) instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned OT_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     c_req,
    input  logic [N_REQ-1:0]     c_we,
    input  logic [N_REQ*64-1:0]  c_addr,
    input  logic [N_REQ*64-1:0]  c_wdata,
    output logic [N_REQ-1:0]     c_gnt,
    output logic [N_REQ-1:0]     c_valid,
    output logic [63:0]          c_rdata,
    output logic                 m_req,
    output logic                 m_we,
    output logic [63:0]          m_addr,
    output logic [63:0]          m_wdata,
    input  logic                 m_gnt,
    input  logic                 m_valid,
    input  logic [63:0]          m_rdata,
    output logic                 rsp_err
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned PTR_W = (OT_DEPTH > 1) ? $clog2(OT_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GRANT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   winner_q, winner_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic               mask_q, mask_d;
    logic               m_req_q, m_req_d;
    logic               m_we_q, m_we_d;
    logic [63:0]        m_addr_q, m_addr_d;
    logic [63:0]        m_wdata_q, m_wdata_d;
    logic [N_REQ-1:0]   c_gnt_q, c_gnt_d;

    logic [IDX_W-1:0]   fifo_q [OT_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [N_REQ-1:0]   c_valid_q;
    logic [63:0]        c_rdata_q;
    logic               rsp_err_q;

    logic               w_full;
    logic [N_REQ-1:0]   w_mask;
    logic [N_REQ-1:0]   w_elig;
    logic               w_found;
    logic [IDX_W-1:0]   w_pick;
    logic               w_push;
    logic               w_pop;

    // Eligibility: masked last winner right after GRANT, reads blocked when FIFO is full
    assign w_full = (count_q == CNT_W'(OT_DEPTH));
    assign w_mask = mask_q ? (N_REQ'(1) << winner_q) : '0;
    assign w_elig = c_req & ~w_mask & (c_we | {N_REQ{~w_full}});

    // Winner selection among eligible requesters
    always_comb begin
        logic [IDX_W:0] cand;
        w_found = 1'b0;
        w_pick  = '0;
        cand    = '0;
`ifdef MEM_ARB_FIXED_PRIO_EN
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_elig[k]) begin
                w_found = 1'b1;
                w_pick  = IDX_W'(k);
            end
        end
`else
        // Search starts one past the last winner, wrapping at N_REQ
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, last_q} + (IDX_W+1)'(1) + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_REQ)) begin
                cand = cand - (IDX_W+1)'(N_REQ);
            end
            if (!w_found && w_elig[cand[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = cand[IDX_W-1:0];
            end
        end
`endif
    end

    // FSM next-state and registered-output next values
    always_comb begin
        state_d   = state_q;
        winner_d  = winner_q;
        last_d    = last_q;
        mask_d    = (state_q == GRANT);
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        c_gnt_d   = '0;
        w_push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_found) begin
                    winner_d  = w_pick;
                    m_req_d   = 1'b1;
                    m_we_d    = c_we[w_pick];
                    m_addr_d  = c_addr[w_pick*64 +: 64];
                    m_wdata_d = c_wdata[w_pick*64 +: 64];
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (m_gnt) begin
                    m_req_d = 1'b0;
                    c_gnt_d = N_REQ'(1) << winner_q;
                    last_d  = winner_q;
                    w_push  = ~m_we_q;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                m_req_d = 1'b0;
            end
        endcase
    end

    // FSM and downstream request registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            winner_q  <= '0;
            last_q    <= IDX_W'(N_REQ - 1);
            mask_q    <= 1'b0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            c_gnt_q   <= '0;
        end else begin
            state_q   <= state_d;
            winner_q  <= winner_d;
            last_q    <= last_d;
            mask_q    <= mask_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            c_gnt_q   <= c_gnt_d;
        end
    end

    // A return only pops when an owner is recorded; otherwise it is an error
    assign w_pop = m_valid && (count_q != '0);

    // Owner FIFO and read-return path, independent of the issue FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OT_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            c_valid_q <= '0;
            c_rdata_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            if (w_push) begin
                fifo_q[wr_ptr_q] <= winner_q;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
                c_valid_q <= N_REQ'(1) << fifo_q[rd_ptr_q];
                c_rdata_q <= m_rdata;
            end else begin
                c_valid_q <= '0;
            end
            count_q <= count_q + CNT_W'(w_push) - CNT_W'(w_pop);
            if (m_valid && (count_q == '0)) begin
                rsp_err_q <= 1'b1;
            end
        end
    end

    assign c_gnt   = c_gnt_q;
    assign c_valid = c_valid_q;
    assign c_rdata = c_rdata_q;
    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign rsp_err = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter (round-robin
//               build): grant order/spacing, FIFO-full blocking, read return
//               routing, unsolicited-return error and mid-ISSUE reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   c_req, c_we;
    logic [N*64-1:0] c_addr, c_wdata;
    logic [N-1:0]   c_gnt, c_valid;
    logic [63:0]    c_rdata;
    logic           m_req, m_we;
    logic [63:0]    m_addr, m_wdata;
    logic           m_gnt, m_valid;
    logic [63:0]    m_rdata;
    logic           rsp_err;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    mem_arbiter #(.N_REQ(N), .OT_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_valid(c_valid), .c_rdata(c_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_valid(m_valid), .m_rdata(m_rdata),
        .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for any grant pulse; g stays 0 if none arrives
    task automatic wait_gnt(output logic [N-1:0] g, output int n);
        g = '0;
        n = 0;
        while (n < 12 && g == '0) begin
            tick();
            n++;
            g = c_gnt;
        end
    endtask

    initial begin
        logic [N-1:0] g;
        int           n;
        logic [N-1:0] exp_own [4];

        rst_n   = 1'b0;
        c_req   = '0;
        c_we    = '0;
        c_addr  = '0;
        c_wdata = '0;
        m_gnt   = 1'b0;
        m_valid = 1'b0;
        m_rdata = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_c_gnt",   c_gnt,   0);
        check("rst_c_valid", c_valid, 0);
        check("rst_m_req",   m_req,   0);
        check("rst_m_addr",  m_addr,  0);
        check("rst_rsp_err", rsp_err, 0);

        // Four simultaneous reads, m_gnt tied high: order 0..3, 3 cycles apart
        for (int i = 0; i < N; i++) begin
            c_addr[64*i +: 64] = 64'h1000 + 64'(i * 8);
        end
        m_gnt = 1'b1;
        c_req = 4'b1111;
        for (int i = 0; i < N; i++) begin
            wait_gnt(g, n);
            check($sformatf("rr_gnt%0d", i), g, 64'(1) << i);
            check($sformatf("rr_gap%0d", i), n, (i == 0) ? 2 : 3);
            check($sformatf("rr_addr%0d", i), m_addr, 64'h1000 + 64'(i * 8));
            c_req = c_req & ~g;
        end
        check("fifo_count4", dut.count_q, 4);

        // FIFO full: core 3 write wins, core 1 read waits for a pop
        c_we[3] = 1'b1;
        c_wdata[3*64 +: 64] = 64'h33;
        c_req = 4'b1010;
        wait_gnt(g, n);
        check("full_wr_gnt", g, 4'b1000);
        check("full_wr_we",  m_we, 1);
        check("full_wr_dat", m_wdata, 64'h33);
        c_req[3] = 1'b0;
        c_we[3]  = 1'b0;
        wait_gnt(g, n);
        check("full_rd_held", g, 0);
        m_valid = 1'b1;
        m_rdata = 64'hA0;
        tick();
        m_valid = 1'b0;
        check("pop0_valid", c_valid, 4'b0001);
        check("pop0_rdata", c_rdata, 64'hA0);
        wait_gnt(g, n);
        check("full_rd_gnt", g, 4'b0010);
        c_req = '0;

        // Drain: owners in order 1,2,3,1
        exp_own[0] = 4'b0010;
        exp_own[1] = 4'b0100;
        exp_own[2] = 4'b1000;
        exp_own[3] = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            m_valid = 1'b1;
            m_rdata = 64'h1000 + 64'(k);
            tick();
            check($sformatf("drain_valid%0d", k), c_valid, exp_own[k]);
            check($sformatf("drain_rdata%0d", k), c_rdata, 64'h1000 + 64'(k));
        end
        m_valid = 1'b0;
        tick();
        check("drain_idle", c_valid, 0);
        check("drain_err",  rsp_err, 0);

        // Core 2 read to 0xC8, return two cycles after grant
        c_addr[2*64 +: 64] = 64'hC8;
        c_req = 4'b0100;
        wait_gnt(g, n);
        check("c2_gnt",  g, 4'b0100);
        check("c2_addr", m_addr, 64'hC8);
        check("c2_we",   m_we, 0);
        c_req = '0;
        tick();
        m_valid = 1'b1;
        m_rdata = 64'hDEADBEEF;
        tick();
        m_valid = 1'b0;
        check("c2_valid", c_valid, 4'b0100);
        check("c2_rdata", c_rdata, 64'hDEADBEEF);

        // Unsolicited return: no c_valid, sticky error
        m_valid = 1'b1;
        m_rdata = 64'h55;
        tick();
        m_valid = 1'b0;
        check("err_no_valid", c_valid, 0);
        check("err_set", rsp_err, 1);
        tick();
        tick();
        check("err_sticky", rsp_err, 1);

        // Reset while in ISSUE with m_gnt low
        m_gnt = 1'b0;
        c_we  = 4'b0010;
        c_req = 4'b0010;
        n = 0;
        while (n < 10 && !m_req) begin
            tick();
            n++;
        end
        check("iss_m_req", m_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_m_req",   m_req,   0);
        check("arst_m_we",    m_we,    0);
        check("arst_m_addr",  m_addr,  0);
        check("arst_rsp_err", rsp_err, 0);
        c_req = '0;
        c_we  = '0;
        #10;
        rst_n = 1'b1;
        tick();
        m_valid = 1'b1;
        tick();
        m_valid = 1'b0;
        check("post_rst_err", rsp_err, 1);
        m_gnt = 1'b1;
        c_req = 4'b1011;
        wait_gnt(g, n);
        check("post_rst_gnt", g, 4'b0001);
        c_req = '0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
